// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
// Datapath for the small 8-bit teaching processor. It holds the program
// counter, instruction register, 16x8 register file, a 4-function ALU and an
// internal 256x8 data memory. A separate controller sequences it through the
// control inputs below.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   PC_clr, PC_inc, PC_ld        PC clear / increment / jump to IR[7:0]
//   I_rd, IR_ld                  instruction fetch enables (both needed to load IR)
//   I_addr      (out, 8)         instruction memory address (= PC)
//   I_data      (in, 16)         instruction memory read data
//   instruction (out, 16)        current IR contents
//   D_addr, D_rd, D_wr           data memory address / read / write
//   RF_W_data   (in, 8)          immediate write data
//   RF_s1, RF_s0                 RF write source: 00 ALU, 01 mem, 10 imm, 11 zero
//   RF_W_addr, RF_W_wr           RF write port
//   RF_Rp_addr/rd, RF_Rq_addr/rd RF read ports (data forced to 0 when not read)
//   alu_s1, alu_s0               ALU op: 00 pass Rp, 01 add, 10 sub, 11 not Rp
//   RF_Rp_zero  (out)            Rp port reads a zero register
//   dbg_addr, dbg_data           combinational register file peek
//   pc          (out, 8)         current PC
// -----------------------------------------------------------------------------
module cpu_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_clr,
    input  logic        PC_inc,
    input  logic        PC_ld,
    input  logic        I_rd,
    input  logic        IR_ld,
    output logic [7:0]  I_addr,
    input  logic [15:0] I_data,
    output logic [15:0] instruction,
    input  logic [7:0]  D_addr,
    input  logic        D_rd,
    input  logic        D_wr,
    input  logic [7:0]  RF_W_data,
    input  logic        RF_s1,
    input  logic        RF_s0,
    input  logic [3:0]  RF_W_addr,
    input  logic        RF_W_wr,
    input  logic [3:0]  RF_Rp_addr,
    input  logic        RF_Rp_rd,
    input  logic [3:0]  RF_Rq_addr,
    input  logic        RF_Rq_rd,
    input  logic        alu_s1,
    input  logic        alu_s0,
    output logic        RF_Rp_zero,
    input  logic [3:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [7:0]  pc
);

    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic [7:0]  regs [16];
    logic [7:0]  dmem [256];

    logic [7:0]  rp_data;
    logic [7:0]  rq_data;
    logic [7:0]  alu_result;
    logic [7:0]  mem_rdata;
    logic [7:0]  rf_wdata;

    // Program counter: clear beats jump beats increment; 8-bit add wraps 255 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 8'h00;
        end else if (PC_clr) begin
            pc_q <= 8'h00;
        end else if (PC_ld) begin
            pc_q <= ir_q[7:0];
        end else if (PC_inc) begin
            pc_q <= pc_q + 8'h01;
        end
    end

    // Instruction register: I_data is addressed by the pre-edge PC, so a
    // fetch combined with PC_inc captures the word at the old PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= 16'h0000;
        end else if (IR_ld && I_rd) begin
            ir_q <= I_data;
        end
    end

    // Register file write port; reads are asynchronous and see pre-edge
    // contents, so there is no write-to-read bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (RF_W_wr) begin
            regs[RF_W_addr] <= rf_wdata;
        end
    end

    // Data memory keeps its contents across reset; a write coinciding with
    // reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && D_wr) begin
            dmem[D_addr] <= rp_data;
        end
    end

    // Read ports, ALU and write-source select are all combinational.
    always_comb begin
        rp_data    = RF_Rp_rd ? regs[RF_Rp_addr] : 8'h00;
        rq_data    = RF_Rq_rd ? regs[RF_Rq_addr] : 8'h00;
        mem_rdata  = D_rd ? dmem[D_addr] : 8'h00;

        alu_result = rp_data;
        case ({alu_s1, alu_s0})
            2'b00:   alu_result = rp_data;
            2'b01:   alu_result = rp_data + rq_data;
            2'b10:   alu_result = rp_data - rq_data;
            default: alu_result = ~rp_data;
        endcase

        rf_wdata = alu_result;
        case ({RF_s1, RF_s0})
            2'b00:   rf_wdata = alu_result;
            2'b01:   rf_wdata = mem_rdata;
            2'b10:   rf_wdata = RF_W_data;
            default: rf_wdata = 8'h00;
        endcase
    end

    assign RF_Rp_zero  = RF_Rp_rd && (regs[RF_Rp_addr] == 8'h00);
    assign dbg_data    = regs[dbg_addr];
    assign pc          = pc_q;
    assign I_addr      = pc_q;
    assign instruction = ir_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
// Directed bench for cpu_datapath. The stimulus process drives one control
// word per clock and pushes hand-computed expectations into a scoreboard
// queue; a monitor process pops one entry per falling edge and compares it
// against the DUT outputs (or a register peeked through the debug port).
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_clr, PC_inc, PC_ld;
    logic        I_rd, IR_ld;
    logic [7:0]  I_addr;
    logic [15:0] I_data;
    logic [15:0] instruction;
    logic [7:0]  D_addr;
    logic        D_rd, D_wr;
    logic [7:0]  RF_W_data;
    logic        RF_s1, RF_s0;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        RF_Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        RF_Rq_rd;
    logic        alu_s1, alu_s0;
    logic        RF_Rp_zero;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [7:0]  pc;

    logic [15:0] imem [256];

    typedef enum int {K_PC, K_IADDR, K_INSTR, K_REG, K_ZERO} kind_t;

    typedef struct {
        kind_t       kind;
        logic [3:0]  addr;
        logic [15:0] exp;
        string       name;
    } expect_t;

    expect_t sb[$];
    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    assign I_data = imem[I_addr];

    cpu_datapath dut (
        .clk(clk), .rst(rst),
        .PC_clr(PC_clr), .PC_inc(PC_inc), .PC_ld(PC_ld),
        .I_rd(I_rd), .IR_ld(IR_ld),
        .I_addr(I_addr), .I_data(I_data), .instruction(instruction),
        .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .RF_W_data(RF_W_data), .RF_s1(RF_s1), .RF_s0(RF_s0),
        .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Rp_addr(RF_Rp_addr), .RF_Rp_rd(RF_Rp_rd),
        .RF_Rq_addr(RF_Rq_addr), .RF_Rq_rd(RF_Rq_rd),
        .alu_s1(alu_s1), .alu_s0(alu_s0),
        .RF_Rp_zero(RF_Rp_zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pc(pc)
    );

    // Monitor: one scoreboard entry per falling edge, well away from the
    // rising edge where state changes.
    initial begin
        expect_t     e;
        logic [15:0] act;
        dbg_addr = 4'h0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.kind == K_REG) dbg_addr = e.addr;
                #1;
                case (e.kind)
                    K_PC:    act = {8'h00, pc};
                    K_IADDR: act = {8'h00, I_addr};
                    K_INSTR: act = instruction;
                    K_REG:   act = {8'h00, dbg_data};
                    default: act = {15'h0000, RF_Rp_zero};
                endcase
                checkCount++;
                if (act !== e.exp) begin
                    errorCount++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic goIdle();
        PC_clr = 0; PC_inc = 0; PC_ld = 0;
        I_rd = 0; IR_ld = 0;
        D_rd = 0; D_wr = 0;
        RF_W_wr = 0;
    endtask

    // Present the current control word for exactly one rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        goIdle();
    endtask

    task automatic checkOutput(input kind_t kind, input logic [3:0] addr,
                               input logic [15:0] exp, input string name);
        expect_t e;
        e.kind = kind; e.addr = addr; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    // Hold inputs steady until the monitor has consumed every expectation.
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic locWrite(input logic [3:0] r, input logic [7:0] v);
        RF_s1 = 1; RF_s0 = 0; RF_W_addr = r; RF_W_data = v; RF_W_wr = 1;
        applyStimulus();
    endtask

    task automatic aluWrite(input logic [1:0] op, input logic [3:0] p,
                            input logic [3:0] q, input logic [3:0] w);
        {alu_s1, alu_s0} = op;
        RF_Rp_addr = p; RF_Rp_rd = 1; RF_Rq_addr = q; RF_Rq_rd = 1;
        RF_s1 = 0; RF_s0 = 0; RF_W_addr = w; RF_W_wr = 1;
        applyStimulus();
    endtask

    task automatic storeReg(input logic [3:0] p, input logic [7:0] a);
        RF_Rp_addr = p; RF_Rp_rd = 1; D_addr = a; D_wr = 1;
        applyStimulus();
    endtask

    task automatic loadReg(input logic [7:0] a, input logic rd, input logic [3:0] w);
        D_addr = a; D_rd = rd; RF_s1 = 0; RF_s0 = 1; RF_W_addr = w; RF_W_wr = 1;
        applyStimulus();
    endtask

    // Directed sequence.
    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0] = 16'h3105;
        imem[1] = 16'h7042;
        goIdle();
        D_addr = 0; RF_W_data = 0; RF_s1 = 0; RF_s0 = 0; RF_W_addr = 0;
        RF_Rp_addr = 0; RF_Rp_rd = 0; RF_Rq_addr = 0; RF_Rq_rd = 0;
        alu_s1 = 0; alu_s0 = 0;

        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        RF_Rp_addr = 4'd7; RF_Rp_rd = 1;
        checkOutput(K_PC, 0, 16'h0000, "reset_pc");
        checkOutput(K_IADDR, 0, 16'h0000, "reset_iaddr");
        checkOutput(K_INSTR, 0, 16'h0000, "reset_instr");
        checkOutput(K_ZERO, 0, 16'h0001, "reset_rpzero");
        checkOutput(K_REG, 4'd5, 16'h0000, "reset_r5");
        drain();

        // Fetch with increment captures the word at the old PC.
        I_rd = 1; IR_ld = 1; PC_inc = 1;
        applyStimulus();
        checkOutput(K_INSTR, 0, 16'h3105, "fetch_instr");
        checkOutput(K_PC, 0, 16'h0001, "fetch_pc");
        drain();

        // IR_ld without I_rd must hold the IR.
        IR_ld = 1;
        applyStimulus();
        checkOutput(K_INSTR, 0, 16'h3105, "ir_hold_no_ird");
        drain();

        // LOC then ADD with wrap.
        locWrite(4'd1, 8'hF0);
        locWrite(4'd2, 8'h20);
        aluWrite(2'b01, 4'd1, 4'd2, 4'd3);
        checkOutput(K_REG, 4'd1, 16'h00F0, "loc_r1");
        checkOutput(K_REG, 4'd3, 16'h0010, "add_wrap_r3");
        drain();

        // SUB with borrow wrap, NOT, and pass-through.
        locWrite(4'd1, 8'h05);
        locWrite(4'd2, 8'h07);
        aluWrite(2'b10, 4'd1, 4'd2, 4'd5);
        aluWrite(2'b11, 4'd1, 4'd2, 4'd6);
        aluWrite(2'b00, 4'd2, 4'd1, 4'd9);
        checkOutput(K_REG, 4'd5, 16'h00FE, "sub_r5");
        checkOutput(K_REG, 4'd6, 16'h00FA, "not_r6");
        checkOutput(K_REG, 4'd9, 16'h0007, "pass_r9");
        drain();

        // Same-register read and write: ALU sees the pre-edge value.
        locWrite(4'd8, 8'h11);
        aluWrite(2'b01, 4'd8, 4'd8, 4'd8);
        checkOutput(K_REG, 4'd8, 16'h0022, "nobypass_r8");
        drain();

        // Write source 11 forces zero.
        RF_s1 = 1; RF_s0 = 1; RF_W_addr = 4'd9; RF_W_wr = 1;
        applyStimulus();
        checkOutput(K_REG, 4'd9, 16'h0000, "src11_r9");
        drain();

        // Store and load; D_rd=0 makes memory data read as zero.
        locWrite(4'd1, 8'hA5);
        storeReg(4'd1, 8'h3C);
        loadReg(8'h3C, 1'b1, 4'd4);
        locWrite(4'd7, 8'h55);
        loadReg(8'h3C, 1'b0, 4'd7);
        checkOutput(K_REG, 4'd4, 16'h00A5, "load_r4");
        checkOutput(K_REG, 4'd7, 16'h0000, "load_nord_r7");
        drain();

        // Disabled RF write leaves the target alone.
        RF_s1 = 1; RF_s0 = 0; RF_W_addr = 4'd4; RF_W_data = 8'h99; RF_W_wr = 0;
        applyStimulus();
        checkOutput(K_REG, 4'd4, 16'h00A5, "nowr_r4");
        drain();

        // Zero flag.
        locWrite(4'd2, 8'h00);
        RF_Rp_addr = 4'd2; RF_Rp_rd = 1;
        checkOutput(K_ZERO, 0, 16'h0001, "zero_r2");
        drain();
        RF_Rp_rd = 0;
        checkOutput(K_ZERO, 0, 16'h0000, "zero_nord");
        drain();
        RF_Rp_addr = 4'd1; RF_Rp_rd = 1;
        checkOutput(K_ZERO, 0, 16'h0000, "zero_r1_nonzero");
        drain();

        // Jump, clear priority, wrap.
        I_rd = 1; IR_ld = 1;
        applyStimulus();
        PC_ld = 1;
        applyStimulus();
        checkOutput(K_INSTR, 0, 16'h7042, "fetch2_instr");
        checkOutput(K_PC, 0, 16'h0042, "jump_pc");
        drain();
        PC_clr = 1; PC_ld = 1; PC_inc = 1;
        applyStimulus();
        checkOutput(K_PC, 0, 16'h0000, "clr_priority_pc");
        drain();
        imem[0] = 16'h00FF;
        I_rd = 1; IR_ld = 1;
        applyStimulus();
        PC_ld = 1; PC_inc = 1;
        applyStimulus();
        checkOutput(K_PC, 0, 16'h00FF, "ld_over_inc_pc");
        drain();
        PC_inc = 1;
        applyStimulus();
        checkOutput(K_PC, 0, 16'h0000, "wrap_pc");
        drain();

        // Reset cancels the RF write, PC load and memory write of its cycle.
        storeReg(4'd3, 8'h10);
        rst = 1;
        RF_s1 = 1; RF_s0 = 0; RF_W_addr = 4'd9; RF_W_data = 8'h77; RF_W_wr = 1;
        PC_ld = 1; RF_Rp_addr = 4'd1; RF_Rp_rd = 1; D_addr = 8'h10; D_wr = 1;
        applyStimulus();
        rst = 0;
        checkOutput(K_PC, 0, 16'h0000, "rst_pc");
        checkOutput(K_INSTR, 0, 16'h0000, "rst_instr");
        checkOutput(K_REG, 4'd1, 16'h0000, "rst_r1");
        checkOutput(K_REG, 4'd4, 16'h0000, "rst_r4");
        checkOutput(K_REG, 4'd9, 16'h0000, "rst_r9");
        checkOutput(K_ZERO, 0, 16'h0001, "rst_rpzero");
        drain();
        loadReg(8'h3C, 1'b1, 4'd10);
        loadReg(8'h10, 1'b1, 4'd11);
        checkOutput(K_REG, 4'd10, 16'h00A5, "mem_kept_3c");
        checkOutput(K_REG, 4'd11, 16'h0010, "mem_wr_cancel_10");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run still active, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 No parameters; all widths fixed: 16-bit instruction, 8-bit data, 8-bit PC, 16x8 register file, 256x8 data memory.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 PC_clr, PC_inc, PC_ld  in  1 each  program counter clear / increment / load-jump controls.
REQ-005 I_rd, IR_ld  in  1 each  instruction fetch read and IR load enables.
REQ-006 I_addr  out  8  instruction memory address, equal to PC.
REQ-007 I_data  in  16  instruction memory read data, combinational from I_addr.
REQ-008 instruction  out  16  current IR contents, to controller.
REQ-009 D_addr  in  8  data memory address; D_rd, D_wr  in  1 each  data memory read / write enables.
REQ-010 RF_W_data  in  8  immediate write data (LOC).
REQ-011 RF_s1, RF_s0  in  1 each  register file write source select.
REQ-012 RF_W_addr  in  4, RF_W_wr  in  1  register file write port.
REQ-013 RF_Rp_addr  in  4, RF_Rp_rd  in  1, RF_Rq_addr  in  4, RF_Rq_rd  in  1  register file read ports.
REQ-014 alu_s1, alu_s0  in  1 each  ALU operation select.
REQ-015 RF_Rp_zero  out  1  Rp read data equals zero, to controller.
REQ-016 dbg_addr  in  4, dbg_data  out  8  combinational debug read of register file.
REQ-017 pc  out  8  current PC value.

Function
REQ-018 PC update priority per cycle SHALL be: PC_clr -> 0; else PC_ld -> IR[7:0]; else PC_inc -> PC+1 (modulo 256, 255 wraps to 0); else hold.
REQ-019 IR SHALL load I_data at the clock edge where IR_ld=1 and I_rd=1; otherwise hold.
REQ-020 IR_ld and PC_inc in the same cycle SHALL capture the word at the pre-increment PC.
REQ-021 Rp_data SHALL be RF[RF_Rp_addr] when RF_Rp_rd=1, else 8'h00; Rq_data likewise for Rq.
REQ-022 RF_Rp_zero SHALL be combinational: 1 iff RF_Rp_rd=1 and RF[RF_Rp_addr]==0; 0 when RF_Rp_rd=0.
REQ-023 ALU SHALL compute, all 8-bit, no carry/borrow out: {s1,s0}=00 Rp_data; 01 Rp_data+Rq_data mod 256; 10 Rp_data-Rq_data mod 256; 11 ~Rp_data.
REQ-024 RF write data SHALL be selected by {RF_s1,RF_s0}: 00 ALU result; 01 data memory read data; 10 RF_W_data; 11 8'h00.
REQ-025 RF SHALL write at the clock edge when RF_W_wr=1; no write when 0; register 0 is general purpose.
REQ-026 RF reads SHALL return the pre-edge value when reading and writing the same register in one cycle (no bypass).
REQ-027 Data memory SHALL be internal, 256x8, asynchronous read at D_addr, synchronous write of Rp_data to D_addr when D_wr=1.
REQ-028 D_rd=0 SHALL force data memory read data to 8'h00; simultaneous D_rd and D_wr SHALL write and return the pre-edge value.
REQ-029 Address/data inputs qualified by an enable SHALL have no effect while that enable is 0.
REQ-030 ALU, write-source mux, memory reads and RF_Rp_zero SHALL be purely combinational; zero added cycles.

Reset
REQ-031 rst=1 at a clock edge SHALL set PC=0, IR=16'h0000 and all 16 registers to 8'h00, overriding every control input.
REQ-032 Data memory contents SHALL NOT be reset.
REQ-033 Reset mid-instruction SHALL cancel the pending RF write, PC load and memory write in that cycle.
REQ-034 After reset release: I_addr=0, instruction=0, RF_Rp_zero=1 whenever RF_Rp_rd=1.

Verification
REQ-035 Fetch: I_data=16'h3105 at PC=0, IR_ld=I_rd=PC_inc=1 for one cycle -> instruction=16'h3105, pc=1.
REQ-036 LOC/ADD: write 8'hF0 to r1 and 8'h20 to r2 via s=10; then Rp=r1, Rq=r2, alu=01, s=00, W=r3 -> dbg r3=8'h10 (wrap).
REQ-037 SUB/NOT: r1=8'h05, r2=8'h07, alu=10 -> 8'hFE; alu=11 on Rp=r1 -> 8'hFA.
REQ-038 STORE/LOAD: Rp=r1 (8'hA5), D_wr=1, D_addr=8'h3C; next D_rd=1, s=01, W=r4 -> r4=8'hA5.
REQ-039 Jump/zero: r2=0, Rp=r2, Rp_rd=1 -> RF_Rp_zero=1; IR=16'h7042, PC_ld=1 -> pc=8'h42; PC_clr with PC_ld and PC_inc -> pc=0; pc=8'hFF with PC_inc -> 0.
REQ-040 Reset: rst during a cycle with RF_W_wr=1, PC_ld=1 -> all registers, pc and instruction zero; earlier data memory write preserved.
